// File: rtl/reset_seq_if.sv
// Request/status bundle between the reset sequencer and its requesters:
// trigger sources in, per-channel resets and status out.
interface reset_seq_if #(
  parameter int unsigned N_CH = 2
);
  logic            tb_sim_rst;
  logic            bu_rx_data_rdy;
  logic [7:0]      bu_rx_data;
  logic            wdog_kick;
  logic [N_CH-1:0] rst;
  logic            rst_busy;
  logic            rst_done;
  logic [1:0]      rst_cause;
  logic [7:0]      evt_count;

  modport master (
    output tb_sim_rst, bu_rx_data_rdy, bu_rx_data, wdog_kick,
    input  rst, rst_busy, rst_done, rst_cause, evt_count
  );

  modport slave (
    input  tb_sim_rst, bu_rx_data_rdy, bu_rx_data, wdog_kick,
    output rst, rst_busy, rst_done, rst_cause, evt_count
  );
endinterface

// File: rtl/reset_seq.sv
// Multi-channel reset sequencer: hold all channels, then release them in order.
// Optional watchdog request source enabled by defining RESETSEQ_WDOG_EN.
module reset_seq #(
  parameter int unsigned HOLD      = 16,
  parameter int unsigned N_CH      = 2,
  parameter int unsigned GAP       = 4,
  parameter logic [7:0]  TRIG_CHAR = 8'h1b,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned WD_W      = 24
) (
  input  logic       clk,
  input  logic       resetq,
  reset_seq_if.slave bus
);
  localparam logic [1:0] S_HOLD  = 2'd0;
  localparam logic [1:0] S_STAGE = 2'd1;
  localparam logic [1:0] S_IDLE  = 2'd2;

  localparam logic [1:0] C_SIM = 2'b01;
  localparam logic [1:0] C_KEY = 2'b10;
  localparam logic [1:0] C_WD  = 2'b11;

  logic [1:0]       sync_q;
  logic             run;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [N_CH-1:0]  rst_q, rst_nxt;
  logic             busy_q, done_q, done_nxt;
  logic [1:0]       cause_q, cause_nxt, trig_cause;
  logic [7:0]       evt_q, evt_nxt;
  logic             key_hit, wdog_expire, trig;

  // Release of resetq is synchronised; the sequencer stays parked until it lands.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) sync_q <= 2'b00;
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    else         sync_q <= {sync_q[0], 1'b1};
  end
  assign run = sync_q[1];

  assign key_hit = bus.bu_rx_data_rdy && (bus.bu_rx_data == TRIG_CHAR);
  assign trig    = bus.tb_sim_rst | key_hit | wdog_expire;

  always_comb begin
    trig_cause = C_WD;
    if (bus.tb_sim_rst)  trig_cause = C_SIM;
    else if (key_hit)    trig_cause = C_KEY;
  end

`ifdef RESETSEQ_WDOG_EN
  logic [WD_W-1:0] wd_cnt;

  assign wdog_expire = (state == S_IDLE) && (&wd_cnt) && !bus.wdog_kick;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)                                       wd_cnt <= '0;
    else if (state != S_IDLE || bus.wdog_kick || trig) wd_cnt <= '0;
    else                                               wd_cnt <= wd_cnt + 1'b1;
  end
`else
  // Constant 0; kick and WD_W are referenced only so they do not dangle.
  assign wdog_expire = 1'b0 & bus.wdog_kick & (WD_W > 0);
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    rst_nxt   = rst_q;
    done_nxt  = 1'b0;
    cause_nxt = cause_q;
    evt_nxt   = evt_q;
    if (trig) begin
      // A request always wins, even against the final release on the same edge.
      state_nxt = S_HOLD;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      rst_nxt   = '1;
      cause_nxt = trig_cause;
      if (evt_q != 8'hff) evt_nxt = evt_q + 8'd1;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == CNT_W'(HOLD - 1)) begin
            cnt_nxt = '0;
            idx_nxt = '0;
            rst_nxt = rst_q << 1;
            if (N_CH == 1) begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = S_STAGE;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_STAGE: begin
          if (cnt == CNT_W'(GAP - 1)) begin
            cnt_nxt = '0;
            idx_nxt = idx + 3'd1;
            rst_nxt = rst_q << 1;
            if (idx_nxt == 3'(N_CH - 1)) begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          rst_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq || !run) begin
      state   <= S_HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_q   <= '1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      cause_q <= 2'b00;
      evt_q   <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      rst_q   <= rst_nxt;
      busy_q  <= |rst_nxt;
      done_q  <= done_nxt;
      cause_q <= cause_nxt;
      evt_q   <= evt_nxt;
    end
  end

  assign bus.rst       = rst_q;
  assign bus.rst_busy  = busy_q;
  assign bus.rst_done  = done_q;
  assign bus.rst_cause = cause_q;
  assign bus.evt_count = evt_q;
endmodule
